operand_loader: RTL and testbench

Serial operand loader that sits directly upstream of the 4-bit bitwise-AND stage. It assembles two WIDTH-bit operands from a 1-bit serial stream, MSB first, A then B. It presents them as top_a/top_b to the AND stage, which is wired port-for-port. A valid/ready handshake tells the consumer when a complete operand pair is stable.

---
 rtl/operand_loader_defs.sv | 18 +
 rtl/sipo_shift.sv | 24 ++
 rtl/operand_loader.sv | 120 ++++++++++++
 tb/tb_operand_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/operand_loader_defs.sv
// rtl/operand_loader_defs.sv - shared state encodings and defaults for the operand loader
package operand_loader_defs;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD_A = 2'd1;
    localparam logic [1:0] ST_LOAD_B = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        LOAD_A = ST_LOAD_A,
        LOAD_B = ST_LOAD_B,
        DONE   = ST_DONE
    } state_t;

endpackage

// File: rtl/sipo_shift.sv
// rtl/sipo_shift.sv - serial-in/parallel-out register, MSB first, with clear and shift enable
module sipo_shift #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    // Clear wins over shift so an abort discards the bit offered in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {q[WIDTH-2:0], din};
        end
    end

endmodule

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - assembles A then B operands from a serial stream for the AND stage
module operand_loader
    import operand_loader_defs::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic [WIDTH-1:0] top_a,
    output logic [WIDTH-1:0] top_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic             accept;
    logic             last_bit;
    logic             clr;
    logic             en_a;
    logic             en_b;

    assign accept   = ser_valid && !start;
    assign last_bit = (cnt == LAST);
    assign clr      = start && ((state != DONE) || out_ready);
    assign en_a     = (state == LOAD_A) && accept;
    assign en_b     = (state == LOAD_B) && accept;

    sipo_shift #(.WIDTH(WIDTH)) u_sh_a (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (en_a),
        .din   (ser_in),
        .q     (sh_a)
    );

    sipo_shift #(.WIDTH(WIDTH)) u_sh_b (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (en_b),
        .din   (ser_in),
        .q     (sh_b)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            top_a     <= '0;
            top_b     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD_A;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                LOAD_A: begin
                    if (start) begin
                        cnt <= '0;
                    end else if (ser_valid) begin
                        if (last_bit) begin
                            state <= LOAD_B;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (start) begin
                        state <= LOAD_A;
                        cnt   <= '0;
                    end else if (ser_valid) begin
                        if (last_bit) begin
                            // Capture B including the bit arriving on this edge.
                            state     <= DONE;
                            cnt       <= '0;
                            top_a     <= sh_a;
                            top_b     <= {sh_b[WIDTH-2:0], ser_in};
                            out_valid <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (start) begin
                            state <= LOAD_A;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - self-checking bench for operand_loader with a frame-level reference model
module tb_operand_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       ser_in = 1'b0;
    logic       ser_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] top_a;
    logic [3:0] top_b;
    logic       out_valid;
    logic       busy;

    int n_checks = 0;
    int n_fail = 0;

    operand_loader #(.WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .top_a     (top_a),
        .top_b     (top_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Frame-level model: a frame is a collection of 8 accepted bits, A in the upper half.
    bit         m_active;
    bit         m_pending;
    int         m_n;
    int         m_val;
    logic [3:0] m_a;
    logic [3:0] m_b;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        bit         gapped;
        int         exp_lat;
        logic [3:0] exp_and;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active  = 0;
        m_pending = 0;
        m_n       = 0;
        m_val     = 0;
        m_a       = '0;
        m_b       = '0;
    endtask

    task automatic model_step(input bit s, input bit v, input bit d, input bit r);
        if (m_pending) begin
            if (r) begin
                m_pending = 0;
                if (s) begin
                    m_active = 1;
                    m_n = 0;
                    m_val = 0;
                end
            end
        end else if (m_active) begin
            if (s) begin
                m_n = 0;
                m_val = 0;
            end else if (v) begin
                m_val = m_val * 2 + int'(d);
                m_n++;
                if (m_n == 8) begin
                    m_a = 4'(m_val / 16);
                    m_b = 4'(m_val % 16);
                    m_pending = 1;
                    m_active = 0;
                end
            end
        end else if (s) begin
            m_active = 1;
            m_n = 0;
            m_val = 0;
        end
    endtask

    task automatic step(input bit s, input bit v, input bit d, input bit r);
        start = s;
        ser_valid = v;
        ser_in = d;
        out_ready = r;
        @(posedge clk);
        model_step(s, v, d, r);
        #1;
        check("model top_a", 32'(top_a), 32'(m_a));
        check("model top_b", 32'(top_b), 32'(m_b));
        check("model out_valid", 32'(out_valid), 32'(m_pending));
        check("model busy", 32'(busy), 32'(m_active));
    endtask

    task automatic send_frame(input logic [3:0] a, input logic [3:0] b, input bit gapped, input int exp_lat);
        logic [7:0] bits;
        int lat;
        int first;
        bits = {a, b};
        first = 0;
        step(1, 0, 0, 0);
        lat = 1;
        for (int i = 7; i >= 0; i--) begin
            if (gapped) begin
                step(0, 0, 1'($urandom), 0);
                lat++;
                if (out_valid && first == 0) first = lat;
            end
            step(0, 1, bits[i], 0);
            lat++;
            if (out_valid && first == 0) first = lat;
        end
        for (int k = 0; k < 10 && first == 0; k++) begin
            step(0, 0, 0, 0);
            lat++;
            if (out_valid) first = lat;
        end
        check("latency", 32'(first), 32'(exp_lat));
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{a: 4'hB, b: 4'h6, gapped: 0, exp_lat: 9,  exp_and: 4'h2};
        vecs[1] = '{a: 4'hB, b: 4'h6, gapped: 1, exp_lat: 17, exp_and: 4'h2};
        vecs[2] = '{a: 4'hF, b: 4'h5, gapped: 0, exp_lat: 9,  exp_and: 4'h5};
        vecs[3] = '{a: 4'h0, b: 4'hF, gapped: 0, exp_lat: 9,  exp_and: 4'h0};
        vecs[4] = '{a: 4'hA, b: 4'h5, gapped: 1, exp_lat: 17, exp_and: 4'h0};
        vecs[5] = '{a: 4'hC, b: 4'hE, gapped: 0, exp_lat: 9,  exp_and: 4'hC};

        model_reset();
        #1 reset = 1'b1;
        #2;
        check("reset top_a", 32'(top_a), 0);
        check("reset top_b", 32'(top_b), 0);
        check("reset out_valid", 32'(out_valid), 0);
        check("reset busy", 32'(busy), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Bits without start are dropped.
        for (int i = 0; i < 5; i++) step(0, 1, 1'($urandom), 0);
        check("idle top_a", 32'(top_a), 0);
        check("idle out_valid", 32'(out_valid), 0);

        foreach (vecs[i]) begin
            send_frame(vecs[i].a, vecs[i].b, vecs[i].gapped, vecs[i].exp_lat);
            check("vec top_a", 32'(top_a), 32'(vecs[i].a));
            check("vec top_b", 32'(top_b), 32'(vecs[i].b));
            check("vec and", 32'(top_a & top_b), 32'(vecs[i].exp_and));
            step(0, 0, 0, 1);
            check("vec consumed", 32'(out_valid), 0);
            step(0, 0, 0, 0);
        end

        // Abort after three A bits; start cycle carries a bit that must be discarded.
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 1, (i % 2 == 1), 0);
        check("abort top_a", 32'(top_a), 32'h0F);
        check("abort top_b", 32'(top_b), 32'h05);

        // Held pair survives start and ser_valid pulses without out_ready.
        for (int i = 0; i < 10; i++) step(1'($urandom), 1'($urandom), 1'($urandom), 0);
        check("hold out_valid", 32'(out_valid), 1);
        check("hold top_a", 32'(top_a), 32'h0F);
        check("hold top_b", 32'(top_b), 32'h05);
        step(1, 0, 0, 1);
        check("restart busy", 32'(busy), 1);
        check("restart out_valid", 32'(out_valid), 0);
        for (int i = 0; i < 8; i++) step(0, 1, (i < 4) ? (i != 0) : (i == 7), 0);
        check("restart top_a", 32'(top_a), 32'h07);
        check("restart top_b", 32'(top_b), 32'h01);
        step(0, 0, 0, 1);

        // Asynchronous reset after six bits of a frame.
        step(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("midreset top_a", 32'(top_a), 0);
        check("midreset top_b", 32'(top_b), 0);
        check("midreset out_valid", 32'(out_valid), 0);
        check("midreset busy", 32'(busy), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        send_frame(4'h3, 4'h9, 0, 9);
        check("postreset top_a", 32'(top_a), 32'h03);
        check("postreset top_b", 32'(top_b), 32'h09);
        step(0, 0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                 $urandom_range(0, 2) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
